branch_track_queue: RTL and testbench
=====================================

# branch_track_queue

Parametrised branch-tracking and PC-redirect unit for the out-of-order MIPS core. It replaces the single-entry branch bookkeeping in hazard control with a DEPTH-entry in-order queue of unresolved conditional branches. It sits between decode (allocation, predicted-taken/jump redirects), ROB commit (resolution, jump-register targets) and fetch (`load_pc`), and produces predictor-training feedback. An optional MIPS delay-slot mode defers decode-side redirects by one decoded instruction.

## Interface
- `ADDR_WIDTH`, 32, PC / target width
- `DEPTH`, 8, queue entries; power of two, ≥2; `TAG_W = $clog2(DEPTH)`
- `GHIST_WIDTH`, 8, global-history snapshot width
- `DELAY_SLOT`, 1, 1 = decode redirects and JR waits start after the next decoded instruction; 0 = immediately
- `clk` in 1: single clock
- `rst_n` in 1: asynchronous, active-low reset
- `alloc_valid` in 1: decode accepts a conditional branch this cycle
- `alloc_pc` / `alloc_recovery` in ADDR_WIDTH: branch PC; target to fetch if the prediction is wrong
- `alloc_pred` in 1: prediction, 1 = taken
- `alloc_ghist` in GHIST_WIDTH: history used for the prediction
- `alloc_ready` out 1: `!full`
- `alloc_tag` out TAG_W: tag the next allocation receives (= write pointer)
- `dec_inst_valid` in 1: decode hands an instruction onward (not stalled)
- `dec_redirect_valid` in 1 / `dec_redirect_target` in ADDR_WIDTH: direct jump or predicted-taken branch
- `jr_alloc` in 1: jump-register accepted at decode
- `jr_resolve_valid` in 1 / `jr_target` in ADDR_WIDTH: JR commits with its target
- `commit_valid` in 1 / `commit_taken` in 1: oldest branch commits with its outcome
- `redirect_we` out 1 / `redirect_pc` out ADDR_WIDTH: fetch PC load
- `flush` out 1: flush decode and younger, same cycle as `redirect_we`
- `jr_stall` out 1: decode stall while a JR target is outstanding
- `fb_valid`, `fb_correct` out 1; `fb_pc` out ADDR_WIDTH; `fb_ghist` out GHIST_WIDTH; `fb_pred` out 1: predictor training
- `count` out TAG_W+1; `full`, `empty` out 1
- `err_overflow`, `err_underflow` out 1: sticky error flags

## Operation
- Queue: circular buffer, `wr_ptr`/`rd_ptr` of TAG_W bits, both wrap modulo DEPTH; `count` 0..DEPTH is tracked separately.
- Allocation: `alloc_valid && !full` writes the entry at `wr_ptr` and increments it. `alloc_valid && full` is dropped, sets `err_overflow`, and is dropped even when a commit occurs in the same cycle.
- Commit: `commit_valid && !empty` reads the entry at `rd_ptr`. A mispredict is `pred != commit_taken`.
  - Correct prediction: `rd_ptr++`.
  - Mispredict: queue emptied (`wr_ptr <= rd_ptr+1`, `rd_ptr <= rd_ptr+1`, `count <= 0`); any same-cycle allocation is discarded; redirect to the entry's `recovery`; the redirect FSM goes to IDLE.
  - `commit_valid` while empty is ignored and sets `err_underflow`.
- Alloc and correct commit in the same cycle: `count` is unchanged.
- Redirect FSM states:
  - IDLE
    - `dec_redirect_valid`: with DELAY_SLOT=0, redirect; with DELAY_SLOT=1, latch the target and go to SLOT.
    - `jr_alloc`: go to WAIT_JR (DELAY_SLOT=0) or SLOT_JR (DELAY_SLOT=1).
  - SLOT: the next `dec_inst_valid` redirects to the latched target and returns to IDLE. Further `dec_redirect_valid`/`jr_alloc` are ignored.
  - SLOT_JR: the next `dec_inst_valid` goes to WAIT_JR.
  - WAIT_JR: `jr_stall=1`. `jr_resolve_valid` redirects to `jr_target` and returns to IDLE.
- Redirect priority within one cycle: mispredict > JR resolve > decode redirect. Lower-priority events are lost, and the FSM returns to IDLE on a mispredict.
- Feedback: registered on every non-empty commit; `fb_correct = (pred == commit_taken)`.

## Timing
- Reset (async): pointers 0, `count` 0, `empty` 1, `full` 0, `alloc_ready` 1, FSM IDLE. All of `redirect_we`, `flush`, `jr_stall`, `fb_*`, `err_*` and `redirect_pc` are 0.
- Reset mid-operation discards all entries and pending redirects immediately.
- `alloc_ready`, `alloc_tag`, `full`, `empty` and `count` reflect registered state (combinational from the registers, no input paths).
- Event at cycle T → `redirect_we`/`flush`/`redirect_pc` at T+1, one-cycle pulse. `fb_*` also appear at T+1.
- `jr_stall` rises the cycle after entering WAIT_JR and falls in the same cycle as the JR `redirect_we`.
- Mispredict at T: `count=0` and `jr_stall=0` at T+1.
- Throughput: one allocation and one commit per cycle.

## Test plan
- DEPTH=8: 8 allocs (preds 1,0,1,…) then 8 correct commits → `full` after 8th, 9th alloc sets `err_overflow`, `fb_correct=1` ×8, `empty` at end, pointers wrapped to 0.
- 3 allocs, commit entry 0 with wrong outcome, recovery 0x400 → T+1 `redirect_we=1`, `redirect_pc=0x400`, `flush=1`, `count=0`, `fb_correct=0`.
- DELAY_SLOT=1: `dec_redirect_valid` target 0x1000, stall 2 cycles, `dec_inst_valid` → redirect to 0x1000 exactly one cycle after `dec_inst_valid`, not before.
- `jr_alloc`, delay-slot instruction, 5 idle cycles, `jr_resolve_valid` target 0x2040 → `jr_stall` high for those cycles, redirect to 0x2040, `jr_stall` low the same cycle.
- Same-cycle mispredict (recovery 0x300), `jr_resolve_valid` (0x500) and `alloc_valid` → `redirect_pc=0x300`, `count=0`, FSM IDLE, `jr_stall=0`.
- Assert `rst_n` low during WAIT_JR with 4 entries → outputs zero asynchronously, `count=0`; `commit_valid` afterwards sets `err_underflow`.

Source files
------------

// File: rtl/branch_track_queue.sv
// branch_track_queue: in-order queue of unresolved conditional branches plus
// the fetch redirect sequencer (mispredict, JR target, decode jump/delay slot).
module branch_track_queue #(
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int GHIST_WIDTH = 8,
    parameter bit DELAY_SLOT = 1'b1,
    localparam int TAG_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   alloc_valid,
    input  logic [ADDR_WIDTH-1:0]  alloc_pc,
    input  logic [ADDR_WIDTH-1:0]  alloc_recovery,
    input  logic                   alloc_pred,
    input  logic [GHIST_WIDTH-1:0] alloc_ghist,
    output logic                   alloc_ready,
    output logic [TAG_W-1:0]       alloc_tag,
    input  logic                   dec_inst_valid,
    input  logic                   dec_redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  dec_redirect_target,
    input  logic                   jr_alloc,
    input  logic                   jr_resolve_valid,
    input  logic [ADDR_WIDTH-1:0]  jr_target,
    input  logic                   commit_valid,
    input  logic                   commit_taken,
    output logic                   redirect_we,
    output logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   flush,
    output logic                   jr_stall,
    output logic                   fb_valid,
    output logic                   fb_correct,
    output logic [ADDR_WIDTH-1:0]  fb_pc,
    output logic [GHIST_WIDTH-1:0] fb_ghist,
    output logic                   fb_pred,
    output logic [TAG_W:0]         count,
    output logic                   full,
    output logic                   empty,
    output logic                   err_overflow,
    output logic                   err_underflow
);
    typedef enum logic [1:0] {IDLE, SLOT, SLOT_JR, WAIT_JR} state_t;

    logic [ADDR_WIDTH-1:0]  q_pc  [DEPTH];
    logic [ADDR_WIDTH-1:0]  q_rec [DEPTH];
    logic [GHIST_WIDTH-1:0] q_gh  [DEPTH];
    logic [DEPTH-1:0]       q_pred;

    logic [TAG_W-1:0]      wr_ptr, rd_ptr, rd_inc;
    logic [TAG_W:0]        cnt;
    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] slot_tgt, slot_tgt_nx, redir_pc_nx;
    logic                  do_alloc, do_commit, mispredict;
    logic                  dec_fire, jr_fire, redir;

    assign full        = cnt == (TAG_W+1)'(DEPTH);
    assign empty       = cnt == '0;
    assign count       = cnt;
    assign alloc_ready = !full;
    assign alloc_tag   = wr_ptr;
    assign jr_stall    = state == WAIT_JR;
    assign rd_inc      = rd_ptr + TAG_W'(1);

    // A mispredict empties the queue, so a same-cycle allocation is younger and discarded.
    assign do_commit  = commit_valid && !empty;
    assign mispredict = do_commit && (q_pred[rd_ptr] != commit_taken);
    assign do_alloc   = alloc_valid && !full && !mispredict;

    always_comb begin
        state_nx    = state;
        slot_tgt_nx = slot_tgt;
        dec_fire    = 1'b0;
        jr_fire     = 1'b0;
        case (state)
            IDLE: begin
                if (dec_redirect_valid) begin
                    if (DELAY_SLOT) begin
                        state_nx    = SLOT;
                        slot_tgt_nx = dec_redirect_target;
                    end else begin
                        dec_fire = 1'b1;
                    end
                end else if (jr_alloc) begin
                    state_nx = DELAY_SLOT ? SLOT_JR : WAIT_JR;
                end
            end
            SLOT: begin
                if (dec_inst_valid) begin
                    dec_fire = 1'b1;
                    state_nx = IDLE;
                end
            end
            SLOT_JR: begin
                if (dec_inst_valid) state_nx = WAIT_JR;
            end
            WAIT_JR: begin
                if (jr_resolve_valid) begin
                    jr_fire  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (mispredict) state_nx = IDLE;
    end

    assign redir       = mispredict || jr_fire || dec_fire;
    assign redir_pc_nx = mispredict ? q_rec[rd_ptr] :
                         jr_fire    ? jr_target :
                         DELAY_SLOT ? slot_tgt : dec_redirect_target;

    always_ff @(posedge clk) begin
        if (do_alloc) begin
            q_pc[wr_ptr]   <= alloc_pc;
            q_rec[wr_ptr]  <= alloc_recovery;
            q_gh[wr_ptr]   <= alloc_ghist;
            q_pred[wr_ptr] <= alloc_pred;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            cnt           <= '0;
            state         <= IDLE;
            slot_tgt      <= '0;
            redirect_we   <= 1'b0;
            flush         <= 1'b0;
            redirect_pc   <= '0;
            fb_valid      <= 1'b0;
            fb_correct    <= 1'b0;
            fb_pc         <= '0;
            fb_ghist      <= '0;
            fb_pred       <= 1'b0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            wr_ptr      <= mispredict ? rd_inc : do_alloc ? wr_ptr + TAG_W'(1) : wr_ptr;
            rd_ptr      <= do_commit ? rd_inc : rd_ptr;
            cnt         <= mispredict ? '0 : cnt + (TAG_W+1)'(do_alloc) - (TAG_W+1)'(do_commit);
            state       <= state_nx;
            slot_tgt    <= slot_tgt_nx;
            redirect_we <= redir;
            flush       <= redir;
            if (redir) redirect_pc <= redir_pc_nx;
            fb_valid    <= do_commit;
            if (do_commit) begin
                fb_correct <= q_pred[rd_ptr] == commit_taken;
                fb_pc      <= q_pc[rd_ptr];
                fb_ghist   <= q_gh[rd_ptr];
                fb_pred    <= q_pred[rd_ptr];
            end
            if (alloc_valid && full) err_overflow <= 1'b1;
            if (commit_valid && empty) err_underflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_branch_track_queue.sv
// tb_branch_track_queue: directed stimulus checked every cycle against a
// queue-based behavioural model, plus hand-computed literal expectations.
module tb_branch_track_queue;
    localparam int AW = 32;
    localparam int D = 8;
    localparam int GW = 8;
    localparam int M_IDLE = 0, M_SLOT = 1, M_SLOT_JR = 2, M_WAIT = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic alloc_valid, alloc_pred, dec_inst_valid, dec_redirect_valid;
    logic jr_alloc, jr_resolve_valid, commit_valid, commit_taken;
    logic [AW-1:0] alloc_pc, alloc_recovery, dec_redirect_target, jr_target;
    logic [GW-1:0] alloc_ghist;
    logic alloc_ready, redirect_we, flush, jr_stall, fb_valid, fb_correct, fb_pred;
    logic full, empty, err_overflow, err_underflow;
    logic [2:0] alloc_tag;
    logic [3:0] count;
    logic [AW-1:0] redirect_pc, fb_pc;
    logic [GW-1:0] fb_ghist;

    int checks = 0, errors = 0;
    bit chk_en = 0;

    branch_track_queue #(.ADDR_WIDTH(AW), .DEPTH(D), .GHIST_WIDTH(GW), .DELAY_SLOT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_pc(alloc_pc), .alloc_recovery(alloc_recovery),
        .alloc_pred(alloc_pred), .alloc_ghist(alloc_ghist), .alloc_ready(alloc_ready),
        .alloc_tag(alloc_tag), .dec_inst_valid(dec_inst_valid),
        .dec_redirect_valid(dec_redirect_valid), .dec_redirect_target(dec_redirect_target),
        .jr_alloc(jr_alloc), .jr_resolve_valid(jr_resolve_valid), .jr_target(jr_target),
        .commit_valid(commit_valid), .commit_taken(commit_taken),
        .redirect_we(redirect_we), .redirect_pc(redirect_pc), .flush(flush),
        .jr_stall(jr_stall), .fb_valid(fb_valid), .fb_correct(fb_correct), .fb_pc(fb_pc),
        .fb_ghist(fb_ghist), .fb_pred(fb_pred), .count(count), .full(full), .empty(empty),
        .err_overflow(err_overflow), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    typedef struct {
        logic [AW-1:0] pc;
        logic [AW-1:0] rec;
        logic          pred;
        logic [GW-1:0] gh;
    } ent_t;

    ent_t mq[$];
    ent_t ce;
    int m_rd = 0, m_wr = 0, m_mode = M_IDLE, sz;
    bit mis;
    logic [AW-1:0] m_tgt = '0, e_pc = '0, e_fbpc = '0;
    logic [GW-1:0] e_fbg = '0;
    logic e_we = 0, e_fbv = 0, e_fbc = 0, e_fbp = 0, e_eo = 0, e_eu = 0;

    // Model: branches as a FIFO of records, redirects as pending-event bookkeeping.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_rd = 0; m_wr = 0; m_mode = M_IDLE;
            e_we = 0; e_fbv = 0; e_eo = 0; e_eu = 0; e_pc = '0;
        end else begin
            sz = mq.size();
            e_we = 0; e_fbv = 0; mis = 0;
            if (alloc_valid && sz == D) e_eo = 1;
            if (commit_valid && sz == 0) e_eu = 1;
            if (commit_valid && sz > 0) begin
                ce = mq.pop_front();
                m_rd = (m_rd + 1) % D;
                e_fbv = 1; e_fbc = (ce.pred == commit_taken);
                e_fbpc = ce.pc; e_fbg = ce.gh; e_fbp = ce.pred;
                mis = !e_fbc;
            end
            if (mis) begin
                mq.delete();
                m_wr = m_rd; m_mode = M_IDLE;
                e_we = 1; e_pc = ce.rec;
            end else begin
                if (alloc_valid && sz < D) begin
                    mq.push_back('{alloc_pc, alloc_recovery, alloc_pred, alloc_ghist});
                    m_wr = (m_wr + 1) % D;
                end
                if (m_mode == M_WAIT && jr_resolve_valid) begin
                    e_we = 1; e_pc = jr_target; m_mode = M_IDLE;
                end else if (m_mode == M_SLOT && dec_inst_valid) begin
                    e_we = 1; e_pc = m_tgt; m_mode = M_IDLE;
                end else if (m_mode == M_SLOT_JR && dec_inst_valid) begin
                    m_mode = M_WAIT;
                end else if (m_mode == M_IDLE && dec_redirect_valid) begin
                    m_mode = M_SLOT; m_tgt = dec_redirect_target;
                end else if (m_mode == M_IDLE && jr_alloc) begin
                    m_mode = M_SLOT_JR;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("redirect_we", redirect_we, e_we);
            chk("flush", flush, e_we);
            if (e_we) chk("redirect_pc", redirect_pc, e_pc);
            chk("jr_stall", jr_stall, m_mode == M_WAIT);
            chk("fb_valid", fb_valid, e_fbv);
            if (e_fbv) begin
                chk("fb_correct", fb_correct, e_fbc);
                chk("fb_pc", fb_pc, e_fbpc);
                chk("fb_ghist", fb_ghist, e_fbg);
                chk("fb_pred", fb_pred, e_fbp);
            end
            chk("count", count, mq.size());
            chk("full", full, mq.size() == D);
            chk("empty", empty, mq.size() == 0);
            chk("alloc_ready", alloc_ready, mq.size() != D);
            chk("alloc_tag", alloc_tag, m_wr);
            chk("err_overflow", err_overflow, e_eo);
            chk("err_underflow", err_underflow, e_eu);
        end
    end

    task automatic idle();
        alloc_valid = 0; alloc_pred = 0; alloc_pc = '0; alloc_recovery = '0; alloc_ghist = '0;
        dec_inst_valid = 0; dec_redirect_valid = 0; dec_redirect_target = '0;
        jr_alloc = 0; jr_resolve_valid = 0; jr_target = '0;
        commit_valid = 0; commit_taken = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc(input logic [AW-1:0] pc, input logic [AW-1:0] rec, input logic pred,
                         input logic [GW-1:0] gh);
        alloc_valid = 1; alloc_pc = pc; alloc_recovery = rec; alloc_pred = pred; alloc_ghist = gh;
        cyc();
        idle();
    endtask

    initial begin
        idle();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        chk_en = 1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ready", alloc_ready, 1);
        chk("rst_redirect", {redirect_we, flush, jr_stall, fb_valid, err_overflow, err_underflow}, 0);
        chk("rst_redirect_pc", redirect_pc, 0);

        // Fill to full, overflow, drain with correct predictions.
        for (int i = 0; i < 8; i++) alloc(32'h100 + 4 * i, 32'h800 + 16 * i, (i % 2) == 0, 8'(i));
        chk("fill_full", full, 1);
        chk("fill_count", count, 8);
        alloc(32'hdead, 32'hbeef, 1, 8'hff);
        chk("overflow_flag", err_overflow, 1);
        chk("overflow_count", count, 8);
        for (int i = 0; i < 8; i++) begin
            commit_valid = 1; commit_taken = (i % 2) == 0;
            cyc();
            idle();
            chk("drain_fb_correct", fb_correct, 1);
            chk("drain_fb_pc", fb_pc, 32'h100 + 4 * i);
        end
        chk("drain_empty", empty, 1);
        chk("drain_tag_wrap", alloc_tag, 0);

        // Mispredict on the oldest of three.
        alloc(32'h40, 32'h400, 1, 8'h11);
        alloc(32'h44, 32'h404, 1, 8'h12);
        alloc(32'h48, 32'h408, 1, 8'h13);
        commit_valid = 1; commit_taken = 0;
        cyc();
        idle();
        chk("mis_we", redirect_we, 1);
        chk("mis_pc", redirect_pc, 32'h400);
        chk("mis_flush", flush, 1);
        chk("mis_count", count, 0);
        chk("mis_fb_correct", fb_correct, 0);
        chk("mis_tag", alloc_tag, 1);
        cyc();
        chk("mis_pulse", redirect_we, 0);

        // Decode redirect waits for its delay-slot instruction.
        dec_redirect_valid = 1; dec_redirect_target = 32'h1000;
        cyc();
        idle();
        chk("slot_wait0", redirect_we, 0);
        cyc();
        chk("slot_wait1", redirect_we, 0);
        cyc();
        chk("slot_wait2", redirect_we, 0);
        dec_inst_valid = 1;
        cyc();
        idle();
        chk("slot_we", redirect_we, 1);
        chk("slot_pc", redirect_pc, 32'h1000);

        // JR with delay slot and a long wait for its target.
        jr_alloc = 1;
        cyc();
        idle();
        chk("jr_slot_stall", jr_stall, 0);
        dec_inst_valid = 1;
        cyc();
        idle();
        chk("jr_stall_on", jr_stall, 1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("jr_stall_hold", jr_stall, 1);
        end
        jr_resolve_valid = 1; jr_target = 32'h2040;
        cyc();
        idle();
        chk("jr_we", redirect_we, 1);
        chk("jr_pc", redirect_pc, 32'h2040);
        chk("jr_stall_off", jr_stall, 0);

        // Mispredict beats a same-cycle JR resolve and allocation.
        alloc(32'h3000, 32'h300, 1, 8'h21);
        jr_alloc = 1;
        cyc();
        idle();
        dec_inst_valid = 1;
        cyc();
        idle();
        commit_valid = 1; commit_taken = 0;
        jr_resolve_valid = 1; jr_target = 32'h500;
        alloc_valid = 1; alloc_pc = 32'h3004; alloc_recovery = 32'h600; alloc_pred = 0;
        cyc();
        idle();
        chk("prio_pc", redirect_pc, 32'h300);
        chk("prio_count", count, 0);
        chk("prio_stall", jr_stall, 0);
        cyc();
        chk("prio_idle_stall", jr_stall, 0);
        chk("prio_pulse", redirect_we, 0);

        // Asynchronous reset while waiting for a JR with entries queued.
        for (int i = 0; i < 4; i++) alloc(32'h5000 + 4 * i, 32'h900, 0, 8'(i));
        jr_alloc = 1;
        cyc();
        idle();
        dec_inst_valid = 1;
        cyc();
        idle();
        chk("pre_rst_stall", jr_stall, 1);
        chk("pre_rst_count", count, 4);
        #1 rst_n = 0;
        #1;
        chk("async_count", count, 0);
        chk("async_empty", empty, 1);
        chk("async_stall", jr_stall, 0);
        chk("async_flags", {redirect_we, flush, fb_valid, err_overflow, err_underflow}, 0);
        chk("async_pc", redirect_pc, 0);
        cyc();
        rst_n = 1;
        commit_valid = 1;
        cyc();
        idle();
        chk("underflow", err_underflow, 1);
        chk("underflow_count", count, 0);
        repeat (3) cyc();
        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
